fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 8 +
 rtl/fetch_unit_if_id_reg.sv | 32 +++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and reset constants for the instruction fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} fetch_state_e;
endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register with load, bubble and hold
module if_id_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [XLEN-1:0] if_id_instr,
  output logic            if_id_valid
);
  // A bubble only drops the valid bit; PC and instruction keep their old values.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (bubble) begin
      if_id_valid <= 1'b0;
    end else if (load) begin
      if_id_pc    <= pc;
      if_id_pc4   <= pc + 32'd4;
      if_id_instr <= instr;
      if_id_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, imem request FSM and IF/ID loading
module fetch_unit
  import fetch_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] TargetedAddress,
  input  logic            PCAddressController,
  input  logic            Stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [XLEN-1:0] IF_ID_PC4,
  output logic [XLEN-1:0] IF_ID_Instr,
  output logic            IF_ID_Valid
);
  fetch_state_e    state, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            load, bubble;
  logic [XLEN-1:0] load_instr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      redir_q <= '0;
      hold_q  <= '0;
    end else begin
      state   <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      hold_q  <= hold_d;
    end
  end

  // imem_addr tracks pc_q directly, so it stays stable until the request completes.
  assign imem_addr = pc_q;

  always_comb begin
    state_d    = state;
    pc_d       = pc_q;
    redir_d    = redir_q;
    hold_d     = hold_q;
    load       = 1'b0;
    bubble     = 1'b0;
    load_instr = imem_rdata;
    imem_req   = 1'b0;
    unique case (state)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (PCAddressController && imem_ready) begin
          pc_d   = TargetedAddress;
          bubble = 1'b1;
        end else if (PCAddressController) begin
          redir_d = TargetedAddress;
          bubble  = 1'b1;
          state_d = DROP;
        end else if (imem_ready && Stall) begin
          hold_d  = imem_rdata;
          state_d = HOLD;
        end else if (imem_ready) begin
          load = 1'b1;
          pc_d = pc_q + 32'd4;
        end else if (!Stall) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        load_instr = hold_q;
        if (PCAddressController) begin
          pc_d    = TargetedAddress;
          bubble  = 1'b1;
          state_d = FETCH;
        end else if (!Stall) begin
          load    = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = FETCH;
        end
      end
      DROP: begin
        imem_req = 1'b1;
        bubble   = 1'b1;
        if (PCAddressController) redir_d = TargetedAddress;
        // The stale word is thrown away; a same-cycle redirect is the newest target.
        if (imem_ready) begin
          pc_d    = PCAddressController ? TargetedAddress : redir_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk        (CLK),
    .reset      (RESET),
    .load       (load),
    .bubble     (bubble),
    .pc         (pc_q),
    .instr      (load_instr),
    .if_id_pc   (IF_ID_PC),
    .if_id_pc4  (IF_ID_PC4),
    .if_id_instr(IF_ID_Instr),
    .if_id_valid(IF_ID_Valid)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a transaction-level model
module tb_fetch_unit;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] TargetedAddress = '0;
  logic        PCAddressController = 1'b0;
  logic        Stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] IF_ID_PC, IF_ID_PC4, IF_ID_Instr;
  logic        IF_ID_Valid;

  always #5 CLK = ~CLK;

  fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .TargetedAddress(TargetedAddress),
    .PCAddressController(PCAddressController), .Stall(Stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .IF_ID_PC(IF_ID_PC), .IF_ID_PC4(IF_ID_PC4),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_Valid(IF_ID_Valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory: latency chosen when a request is first seen; lat < 0 picks it at random.
  int   lat = 0;
  bit   mem_busy = 0;
  int   mem_wait = 0;
  bit   force_ready = 0;
  bit   chk_en = 0;

  // Reference model: fetch pipeline seen as "started / holding a word / discarding a word".
  bit          m_started = 0, m_have_hold = 0, m_drop = 0;
  logic [31:0] m_pc = 0, m_hold = 0, m_redir = 0;
  logic [31:0] e_pc = 0, e_pc4 = 0, e_instr = 32'h13;
  bit          e_valid = 0;

  task automatic commit(input logic [31:0] pc, input logic [31:0] instr);
    e_pc = pc; e_pc4 = pc + 32'd4; e_instr = instr; e_valid = 1;
  endtask

  task automatic model_edge(input bit rst, input bit st, input bit rd, input logic [31:0] tg,
                            input bit rdy, input logic [31:0] rdata);
    if (rst) begin
      m_started = 0; m_have_hold = 0; m_drop = 0; m_pc = 0; m_hold = 0; m_redir = 0;
      e_pc = 0; e_pc4 = 0; e_instr = 32'h13; e_valid = 0;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_have_hold) begin
      if (rd) begin
        m_pc = tg; m_have_hold = 0; e_valid = 0;
      end else if (!st) begin
        commit(m_pc, m_hold); m_pc = m_pc + 32'd4; m_have_hold = 0;
      end
    end else if (m_drop) begin
      e_valid = 0;
      if (rdy) begin
        m_pc = rd ? tg : m_redir; m_drop = 0;
      end else if (rd) m_redir = tg;
    end else begin
      if (rd && rdy) begin
        m_pc = tg; e_valid = 0;
      end else if (rd) begin
        m_redir = tg; m_drop = 1; e_valid = 0;
      end else if (rdy && st) begin
        m_hold = rdata; m_have_hold = 1;
      end else if (rdy) begin
        commit(m_pc, rdata); m_pc = m_pc + 32'd4;
      end else if (!st) e_valid = 0;
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit rd, input logic [31:0] tg);
    bit          rdy;
    logic [31:0] rdata;
    @(negedge CLK);
    if (chk_en) begin
      check("imem_req",   {31'b0, imem_req},    {31'b0, m_started && !m_have_hold});
      check("imem_addr",  imem_addr,            m_pc);
      check("if_id_pc",   IF_ID_PC,             e_pc);
      check("if_id_pc4",  IF_ID_PC4,            e_pc4);
      check("if_id_instr", IF_ID_Instr,         e_instr);
      check("if_id_valid", {31'b0, IF_ID_Valid}, {31'b0, e_valid});
    end
    if (imem_req && !mem_busy && !rst) begin
      mem_busy = 1;
      mem_wait = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
    end
    rdy   = force_ready || (!rst && mem_busy && mem_wait == 0);
    rdata = imem_req ? mem_word(imem_addr) : $urandom;
    RESET = rst; Stall = st; PCAddressController = rd; TargetedAddress = tg;
    imem_ready = rdy; imem_rdata = rdata;
    model_edge(rst, st, rd, tg, rdy, rdata);
    @(posedge CLK);
    if (rst || rdy) mem_busy = 0;
    else if (mem_busy) mem_wait--;
    chk_en = 1;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] tg;
    // Reset values and zero-wait streaming.
    lat = 0;
    do_reset();
    #1;
    check("rst_req",   {31'b0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_instr", IF_ID_Instr, 32'h13);
    check("rst_valid", {31'b0, IF_ID_Valid}, 32'd0);
    check("rst_pc",    IF_ID_PC, 32'h0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1 check("stream_addr", imem_addr, 32'(i * 4));
      step(0, 0, 0, 0);
    end

    // Redirect to 0x100 while fetching 8.
    do_reset();
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    #1 check("pre_redir_addr", imem_addr, 32'h8);
    step(0, 0, 1, 32'h100);
    #1 check("redir_addr", imem_addr, 32'h100);
    check("redir_bubble", {31'b0, IF_ID_Valid}, 32'd0);
    step(0, 0, 0, 0);
    #1 check("redir_ifid_pc", IF_ID_PC, 32'h100);
    check("redir_valid", {31'b0, IF_ID_Valid}, 32'd1);
    step(0, 0, 0, 0);

    // Three wait states; two redirects while the stale request is outstanding.
    lat = 3;
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h200);
    step(0, 0, 1, 32'h300);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    #1 check("drop_addr", imem_addr, 32'h300);
    check("drop_valid", {31'b0, IF_ID_Valid}, 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    #1 check("drop_ifid_pc", IF_ID_PC, 32'h300);
    check("drop_ifid_instr", IF_ID_Instr, mem_word(32'h300));

    // Stall held four cycles while 0x10 returns.
    lat = 0;
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h10);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    #1 check("hold_req", {31'b0, imem_req}, 32'd0);
    step(0, 0, 0, 0);
    #1 check("hold_pc", IF_ID_PC, 32'h10);
    check("hold_pc4", IF_ID_PC4, 32'h14);
    check("hold_instr", IF_ID_Instr, mem_word(32'h10));
    check("hold_next_addr", imem_addr, 32'h14);

    // Redirect together with stall in HOLD.
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'h40);
    #1 check("holdredir_valid", {31'b0, IF_ID_Valid}, 32'd0);
    check("holdredir_addr", imem_addr, 32'h40);
    step(0, 0, 0, 0);

    // Reset in DROP, then a late ready in IDLE.
    lat = 3;
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h80);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    #1 check("rstdrop_req", {31'b0, imem_req}, 32'd0);
    check("rstdrop_addr", imem_addr, 32'h0);
    force_ready = 1;
    step(0, 0, 0, 0);
    force_ready = 0;
    #1 check("idle_ready_addr", imem_addr, 32'h0);
    check("idle_ready_req", {31'b0, imem_req}, 32'd1);
    step(0, 0, 0, 0);

    // Random traffic including wraparound and misaligned targets.
    lat = -1;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: tg = 32'hFFFF_FFFC;
        1: tg = $urandom;
        default: tg = {$urandom_range(0, 255), 2'b00};
      endcase
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 15, tg);
    end
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
